// File: rtl/shared_counter_pkg.sv
// Shared types for the arbitrated shared-counter controller.
package shared_counter_pkg;

    typedef enum logic [1:0] {
        OP_INC  = 2'd0,
        OP_DEC  = 2'd1,
        OP_LOAD = 2'd2,
        OP_READ = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/shared_counter_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps past N-1.
module rr_arbiter
    import shared_counter_pkg::*;
#(
    parameter int N = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    always_comb begin
        logic [IDW:0]   pos;
        logic [IDW-1:0] idx;
        logic           found;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        pos    = '0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            // extra bit keeps ptr+i from overflowing before the wrap back into range
            pos = {1'b0, ptr} + (IDW+1)'(i);
            if (pos >= (IDW+1)'(N)) begin
                pos = pos - (IDW+1)'(N);
            end
            idx = pos[IDW-1:0];
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_counter_ctrl.sv
// Round-robin shared counter controller; define SHARED_COUNTER_CTRL_SAT_EN
// to make INC/DEC saturate instead of wrapping.
//
// state | meaning
// IDLE  | offer req_ready to the round-robin winner; handshake applies the op to count
// EXEC  | count already holds the result; capture response registers
// RESP  | rsp_valid held with stable id/data until rsp_ready
module shared_counter_ctrl
    import shared_counter_pkg::*;
#(
    parameter int  WIDTH = 3,
    parameter int  N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESETN,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [2*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [WIDTH-1:0]       O
);

    state_e           state;
    logic [WIDTH-1:0] count;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   cmd_id;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   ptr_next;
    op_e              sel_op;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] cnt_next;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .en     (state == IDLE),
        .gnt    (req_ready),
        .gnt_id (gnt_id)
    );

    always_comb begin
        sel_op   = OP_READ;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                sel_op   = op_e'(req_op[2*i +: 2]);
                sel_data = req_data[WIDTH*i +: WIDTH];
            end
        end
    end

`ifdef SHARED_COUNTER_CTRL_SAT_EN
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] dif_ext;
    assign sum_ext = {1'b0, count} + (WIDTH+1)'(1);
    assign dif_ext = {1'b0, count} - (WIDTH+1)'(1);

    always_comb begin
        cnt_next = count;
        case (sel_op)
            OP_INC:  cnt_next = sum_ext[WIDTH] ? count : sum_ext[WIDTH-1:0];
            OP_DEC:  cnt_next = dif_ext[WIDTH] ? count : dif_ext[WIDTH-1:0];
            OP_LOAD: cnt_next = sel_data;
            default: cnt_next = count;
        endcase
    end
`else
    always_comb begin
        cnt_next = count;
        case (sel_op)
            OP_INC:  cnt_next = WIDTH'({1'b0, count} + (WIDTH+1)'(1));
            OP_DEC:  cnt_next = WIDTH'({1'b0, count} - (WIDTH+1)'(1));
            OP_LOAD: cnt_next = sel_data;
            default: cnt_next = count;
        endcase
    end
`endif

    assign ptr_next = (gnt_id == IDW'(N_REQ-1)) ? '0 : gnt_id + IDW'(1);

    // The op lands in count on the handshake edge, so O leads rsp_valid by a cycle.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state     <= IDLE;
            count     <= '0;
            ptr       <= '0;
            cmd_id    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        count  <= cnt_next;
                        cmd_id <= gnt_id;
                        ptr    <= ptr_next;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= cmd_id;
                    rsp_data  <= count;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign O = count;

endmodule

// File: tb/tb_shared_counter_ctrl.sv
// Bench for shared_counter_ctrl: vector table plus hand-written corner sequences,
// responses checked against a scoreboard queue.
module tb_shared_counter_ctrl;
    import shared_counter_pkg::*;

    localparam int WIDTH = 3;
    localparam int N_REQ = 4;
    localparam int IDW   = 2;
`ifdef SHARED_COUNTER_CTRL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                   CLK;
    logic                   ASYNCRESETN;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [2*N_REQ-1:0]     req_op;
    logic [WIDTH*N_REQ-1:0] req_data;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [WIDTH-1:0]       rsp_data;
    logic [WIDTH-1:0]       O;

    shared_counter_ctrl #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .O           (O)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        int id;
        int data;
    } rsp_t;
    rsp_t sb[$];

    typedef struct {
        int id;
        int op;
        int data;
        int exp;
    } vec_t;
    vec_t vecs[9];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge CLK) begin
        rsp_t e;
        if (ASYNCRESETN) begin
            check("ready_onehot", int'($countones(req_ready) <= 1), 1);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_rsp: got id %0d data %0d with nothing outstanding",
                             rsp_id, rsp_data);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", int'(rsp_id), e.id);
                    check("rsp_data", int'(rsp_data), e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        ASYNCRESETN = 1'b0;
        req_valid   = '0;
        rsp_ready   = 1'b1;
        repeat (2) tick();
        ASYNCRESETN = 1'b1;
        tick();
    endtask

    task automatic wait_drain(string name);
        int w = 0;
        while (sb.size() != 0 && w < 50) begin
            tick();
            w++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic set_req(int id, int op, int data);
        req_op[2*id +: 2]          = 2'(op);
        req_data[WIDTH*id +: WIDTH] = WIDTH'(data);
    endtask

    task automatic cmd(int id, int op, int data, int exp);
        int w = 0;
        set_req(id, op, data);
        req_valid[id] = 1'b1;
        @(negedge CLK);
        while (!req_ready[id] && w < 50) begin
            @(negedge CLK);
            w++;
        end
        check("grant", int'(req_ready[id]), 1);
        if (!req_ready[id]) begin
            req_valid[id] = 1'b0;
            return;
        end
        sb.push_back('{id, exp});
        tick();
        req_valid[id] = 1'b0;
        check("O_after_hs", int'(O), exp);
        check("rsp_valid_t1", int'(rsp_valid), 0);
        tick();
        check("rsp_valid_t2", int'(rsp_valid), 1);
        wait_drain("cmd_drain");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int last;
        req_valid   = '0;
        req_op      = '0;
        req_data    = '0;
        rsp_ready   = 1'b1;
        ASYNCRESETN = 1'b0;

        vecs[0] = '{0, int'(OP_INC),  0, 1};
        vecs[1] = '{0, int'(OP_INC),  0, 2};
        vecs[2] = '{0, int'(OP_INC),  0, 3};
        vecs[3] = '{2, int'(OP_LOAD), 6, 6};
        vecs[4] = '{2, int'(OP_INC),  0, 7};
        vecs[5] = '{2, int'(OP_INC),  0, SAT ? 7 : 0};
        vecs[6] = '{1, int'(OP_LOAD), 0, 0};
        vecs[7] = '{1, int'(OP_DEC),  0, SAT ? 0 : 7};
        vecs[8] = '{3, int'(OP_READ), 0, SAT ? 0 : 7};

        do_reset();
        check("rst_O", int'(O), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_rsp_id", int'(rsp_id), 0);
        check("rst_rsp_data", int'(rsp_data), 0);

        for (int i = 0; i < 9; i++) begin
            cmd(vecs[i].id, vecs[i].op, vecs[i].data, vecs[i].exp);
        end

        // all requesters continuously valid with READ: strict rotation from 0
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_req(i, int'(OP_READ), 0);
        req_valid = '1;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            @(negedge CLK);
            while (req_ready == '0 && w < 50) begin
                @(negedge CLK);
                w++;
            end
            check("rr_grant", int'(req_ready), 1 << (k % N_REQ));
            if (k > 0) check("rr_gap", cyc - last, 3);
            last = cyc;
            sb.push_back('{k % N_REQ, 0});
            tick();
            wait_drain("rr_drain");
        end
        req_valid = '0;

        // response stall: outputs and count frozen, no new grants
        rsp_ready = 1'b0;
        set_req(1, int'(OP_LOAD), 3);
        req_valid = 4'b0010;
        w = 0;
        @(negedge CLK);
        while (!req_ready[1] && w < 50) begin
            @(negedge CLK);
            w++;
        end
        check("stall_grant", int'(req_ready), 2);
        sb.push_back('{1, 3});
        tick();
        set_req(2, int'(OP_READ), 0);
        req_valid = 4'b0100;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("stall_rsp_valid", int'(rsp_valid), 1);
            check("stall_rsp_id", int'(rsp_id), 1);
            check("stall_rsp_data", int'(rsp_data), 3);
            check("stall_req_ready", int'(req_ready), 0);
            check("stall_O", int'(O), 3);
            tick();
        end
        check("stall_pending", sb.size(), 1);
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_drain("stall_drain");

        // reset during EXEC aborts the LOAD and clears ptr
        set_req(1, int'(OP_LOAD), 5);
        req_valid = 4'b0010;
        w = 0;
        @(negedge CLK);
        while (!req_ready[1] && w < 50) begin
            @(negedge CLK);
            w++;
        end
        check("abort_grant", int'(req_ready), 2);
        tick();
        req_valid = '0;
        check("abort_O_exec", int'(O), 5);
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        check("abort_O_zero", int'(O), 0);
        check("abort_rsp_valid", int'(rsp_valid), 0);
        tick();
        tick();
        ASYNCRESETN = 1'b1;
        tick();
        check("abort_no_rsp", int'(rsp_valid), 0);
        set_req(0, int'(OP_READ), 0);
        set_req(2, int'(OP_READ), 0);
        req_valid = 4'b0101;
        #1;
        check("abort_ptr0", int'(req_ready), 1);
        sb.push_back('{0, 0});
        @(posedge CLK);
        #1;
        req_valid = '0;
        wait_drain("abort_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shared_counter_ctrl.md
# shared_counter_ctrl

Arbitrated controller that shares one WIDTH-bit counter register, the same register-plus-incrementer datapath used by our `Test2` counter, between N_REQ requesters. Each requester issues an increment, decrement, load or read command over a valid/ready handshake. The controller grants one command at a time, round-robin, applies it to the register and returns the resulting count on a single response channel tagged with the requester index. It sits between client blocks and the shared counter datapath and is the only writer of that register.

## Interface
- WIDTH, 3: counter width in bits.
- N_REQ, 4: number of requesters, 2..16.
- IDW, $clog2(N_REQ): response-tag width (derived, not overridden).

- CLK  in  1  clock; all state updates on rising edge.
- ASYNCRESETN  in  1  reset, asynchronous assert, active-low; deassertion synchronous to CLK by the integrator.
- req_valid  in  N_REQ  per-requester command valid.
- req_ready  out  N_REQ  per-requester command accept; one-hot or zero.
- req_op  in  2*N_REQ  per-requester opcode: 0 INC, 1 DEC, 2 LOAD, 3 READ.
- req_data  in  WIDTH*N_REQ  per-requester LOAD value, ignored for other ops.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester being answered.
- rsp_data  out  WIDTH  counter value after the command.
- O  out  WIDTH  live counter value (register output).

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is driven one-hot to the round-robin winner among asserted req_valid bits.
  - The search starts at index ptr and wraps to 0 after N_REQ-1.
  - On handshake, latch op, data and id, set ptr = id+1 mod N_REQ, and go to EXEC.
  - With no valid request, stay in IDLE and drive req_ready = 0.
- EXEC (one cycle):
  - INC: count = count + 1 mod 2^WIDTH.
  - DEC: count = count - 1 mod 2^WIDTH.
  - LOAD: count = data.
  - READ: count unchanged.
  - Go to RESP.
- RESP:
  - rsp_valid = 1, rsp_id = latched id, rsp_data = count; these are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
  - req_ready = 0 throughout.
- Arithmetic: sum and difference are computed at WIDTH+1 bits and truncated to WIDTH; 7+1 → 0 and 0-1 → 7 when WIDTH=3.
- A request whose req_valid drops before grant is not accepted. Requesters must hold req_valid, req_op and req_data until ready.
- Reset values: count = 0, ptr = 0, state IDLE, req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, O = 0.
- Reset asserted mid-command aborts it. No response is issued and count returns to 0.

## Timing
- Request handshake is in cycle t; count updates at the t+1 edge; rsp_valid is high from cycle t+2.
- Minimum 3 cycles per command; peak throughput is 1 command per 3 cycles.
- O reflects the new count one cycle before rsp_valid rises.
- Back-to-back: IDLE can accept a new request in the cycle after the response handshake.
- req_ready depends combinationally on req_valid and state. It has no combinational dependence on rsp_ready.
- No combinational path exists from any input to rsp_*.

## Configuration
- SHARED_COUNTER_CTRL_SAT_EN:
  - Defined: INC at 2^WIDTH-1 holds at 2^WIDTH-1, and DEC at 0 holds at 0.
  - Undefined (default): INC and DEC wrap modulo 2^WIDTH.
  - LOAD and READ behave identically in both builds.

## Structure
- Package shared_counter_pkg:
  - op_e enum: OP_INC=0, OP_DEC=1, OP_LOAD=2, OP_READ=3.
  - state_e enum: IDLE, EXEC, RESP.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs req[N], ptr, en.
  - Outputs gnt[N] (one-hot) and gnt_id.
  - Purely combinational; ptr is held in the parent.
- The parent holds the FSM, the command latch, the counter register and the response registers.

## Test plan
- Reset, then requester 0 INC ×3 → responses rsp_data 1, 2, 3, all rsp_id 0; each rsp_valid rises 2 cycles after its handshake.
- LOAD 6 then INC ×2 from requester 2 → rsp_data 6, 7, 0 in the wrap build; 6, 7, 7 with SHARED_COUNTER_CTRL_SAT_EN defined.
- All 4 requesters continuously valid with READ → grants in order 0, 1, 2, 3, 0; rsp_id follows that order; req_ready is never more than one-hot.
- rsp_ready held low for 5 cycles in RESP → rsp_valid, rsp_id and rsp_data stay stable, req_ready stays 0 and count stays unchanged.
- DEC from 0 → rsp_data 7 in the wrap build and 0 in the saturate build, WIDTH=3.
- ASYNCRESETN pulsed low during EXEC after LOAD 5 → no response, O = 0 immediately, ptr = 0, and the next READ returns 0.
